// File: rtl/ex_muldiv_unit_pkg.sv
// Shared op_type encodings, FSM state type and constants for the EX-stage
// multiply/divide unit; also imported by the ID decoder and hazard unit.
package ex_muldiv_unit_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd9;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_DIV   = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;

    // LO value left behind by any divide whose divisor is zero
    localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mf(input logic [3:0] op);
        return (op == OP_MFHI) || (op == OP_MFLO);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID2EX-side view of the multiply/divide unit: issued operation and operands
// in, stall request, HI/LO and MFHI/MFLO read data out.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);

    logic [3:0]      op_type;
    logic [XLEN-1:0] register_1;
    logic [XLEN-1:0] register_2;
    logic            busy;
    logic [XLEN-1:0] mf_result;
    logic            mf_valid;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output op_type, register_1, register_2,
        input  busy, mf_result, mf_valid, hi, lo
    );

    modport slave (
        input  op_type, register_1, register_2,
        output busy, mf_result, mf_valid, hi, lo
    );

endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes, with a
// final sign-fix cycle that writes the architectural HI/LO registers.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    ex_muldiv_unit_if.slave  bus
);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   operand;
    logic [2*XLEN-1:0] acc;
    logic              op_div_q;
    logic              prod_neg;
    logic              rem_neg;
    logic              div_zero;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;

    logic              start;
    logic              last_iter;
    logic              op_signed;
    logic              op_is_div;
    logic [XLEN-1:0]   rs_mag;
    logic [XLEN-1:0]   rt_mag;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   quo_fixed;
    logic [XLEN-1:0]   rem_fixed;

    always_comb begin
        start     = (state == ST_IDLE) && is_muldiv(bus.op_type);
        last_iter = (cnt == CNT_W'(XLEN - 1));
        op_signed = (bus.op_type == OP_MULT) || (bus.op_type == OP_DIV);
        op_is_div = (bus.op_type == OP_DIV) || (bus.op_type == OP_DIVU);
        rs_mag    = (op_signed && bus.register_1[XLEN-1]) ? -bus.register_1 : bus.register_1;
        rt_mag    = (op_signed && bus.register_2[XLEN-1]) ? -bus.register_2 : bus.register_2;
    end

    // Multiply keeps {partial product, remaining multiplier} in acc and shifts
    // right; divide keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, operand};
        div_ge    = ~div_diff[XLEN+1];
        div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    end

    always_comb begin
        prod_fixed = prod_neg ? -acc : acc;
        rem_fixed  = rem_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        quo_fixed  = prod_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        if (div_zero) begin
            quo_fixed = DIV0_LO;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = op_is_div ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                if (last_iter) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture on start, one iteration per cycle, HI/LO written only
    // on the edge leaving FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            operand  <= '0;
            acc      <= '0;
            op_div_q <= 1'b0;
            prod_neg <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        operand  <= op_is_div ? rt_mag : rs_mag;
                        acc      <= {{XLEN{1'b0}}, (op_is_div ? rs_mag : rt_mag)};
                        op_div_q <= op_is_div;
                        prod_neg <= op_signed && (bus.register_1[XLEN-1] ^ bus.register_2[XLEN-1]);
                        rem_neg  <= op_signed && bus.register_1[XLEN-1];
                        div_zero <= op_is_div && (bus.register_2 == '0);
                    end
                end
                ST_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                end
                ST_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                end
                ST_FIX: begin
                    cnt <= '0;
                    if (op_div_q) begin
                        hi_q <= rem_fixed;
                        lo_q <= quo_fixed;
                    end else begin
                        hi_q <= prod_fixed[2*XLEN-1:XLEN];
                        lo_q <= prod_fixed[XLEN-1:0];
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        bus.busy      = start || (state != ST_IDLE);
        bus.mf_valid  = (state == ST_IDLE) && is_mf(bus.op_type);
        bus.mf_result = '0;
        if (bus.mf_valid) begin
            bus.mf_result = (bus.op_type == OP_MFHI) ? hi_q : lo_q;
        end
        bus.hi = hi_q;
        bus.lo = lo_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: a table of directed mul/div vectors
// plus hand-written sequences for MFHI/MFLO, back-to-back issue and reset abort.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NVEC = 12;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cycles;
    vec_t vecs [NVEC];

    ex_muldiv_unit_if #(.XLEN(32)) bus();

    ex_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic issueOp(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.op_type    = op;
        bus.register_1 = rs;
        bus.register_2 = rt;
        #1;
    endtask

    // Runs until busy drops, feeding the given op as bubble with garbage operands;
    // returns at the first idle cycle with op_type back at NOP.
    task automatic waitIdle(input logic [3:0] bubble, input string name, output int n);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus.op_type    = bubble;
            bus.register_1 = $urandom;
            bus.register_2 = $urandom;
            #1;
            if (!bus.busy) break;
            n++;
            if (n == 5 && bubble != OP_NOP) begin
                checkOutput({name, " mf_valid while busy"}, {31'b0, bus.mf_valid}, 32'd0);
                checkOutput({name, " mf_result while busy"}, bus.mf_result, 32'd0);
            end
        end
        bus.op_type = OP_NOP;
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [3:0] bubble, input string name);
        int n;
        issueOp(op, rs, rt);
        checkOutput({name, " busy on issue"}, {31'b0, bus.busy}, 32'd1);
        waitIdle(bubble, name, n);
        checkOutput({name, " busy cycles"}, n, 32'd34);
    endtask

    initial begin
        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{OP_MULTU, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E};
        vecs[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[10] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[11] = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};

        reset          = 1'b1;
        bus.op_type    = OP_NOP;
        bus.register_1 = '0;
        bus.register_2 = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("reset hi", bus.hi, 32'd0);
        checkOutput("reset lo", bus.lo, 32'd0);
        checkOutput("reset mf_valid", {31'b0, bus.mf_valid}, 32'd0);
        checkOutput("reset mf_result", bus.mf_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, OP_NOP, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d hi", i), bus.hi, vecs[i].exp_hi);
            checkOutput($sformatf("vec%0d lo", i), bus.lo, vecs[i].exp_lo);
        end

        // MFLO/MFHI served with no latency in the first idle cycle
        applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd7, OP_NOP, "mult_mf");
        bus.op_type = OP_MFLO;
        #1;
        checkOutput("mflo valid", {31'b0, bus.mf_valid}, 32'd1);
        checkOutput("mflo result", bus.mf_result, 32'hFFFFFFEB);
        checkOutput("mflo no stall", {31'b0, bus.busy}, 32'd0);
        bus.op_type = OP_MFHI;
        #1;
        checkOutput("mfhi result", bus.mf_result, 32'hFFFFFFFF);
        bus.op_type = OP_NOP;
        #1;

        // Back-to-back: DIVU issued in the first idle cycle after MULT
        applyStimulus(OP_MULT, 32'd2, 32'd3, OP_NOP, "b2b_mult");
        checkOutput("b2b_mult hi", bus.hi, 32'd0);
        checkOutput("b2b_mult lo", bus.lo, 32'd6);
        applyStimulus(OP_DIVU, 32'd9, 32'd4, OP_MFHI, "b2b_divu");
        checkOutput("b2b_divu hi", bus.hi, 32'd1);
        checkOutput("b2b_divu lo", bus.lo, 32'd2);

        // Reset in the 10th busy cycle of a DIVU aborts it
        applyStimulus(OP_MULTU, 32'd5, 32'd6, OP_NOP, "pre_abort");
        checkOutput("pre_abort lo", bus.lo, 32'd30);
        issueOp(OP_DIVU, 32'd100, 32'd7);
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            bus.op_type = OP_NOP;
            #1;
        end
        checkOutput("abort busy before reset", {31'b0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("abort hi", bus.hi, 32'd0);
        checkOutput("abort lo", bus.lo, 32'd0);

        applyStimulus(OP_DIVU, 32'd100, 32'd7, OP_NOP, "post_abort");
        checkOutput("post_abort hi", bus.hi, 32'd2);
        checkOutput("post_abort lo", bus.lo, 32'd14);

        // Reset wins over a start presented in the same cycle
        issueOp(OP_MULT, 32'd3, 32'd3);
        reset = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        bus.op_type = OP_NOP;
        #1;
        checkOutput("reset_prio busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("reset_prio hi", bus.hi, 32'd0);
        checkOutput("reset_prio lo", bus.lo, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_prio stays idle", {31'b0, bus.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
